// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks WIDTH-bit operands LSB first.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s_out,
    output logic c_out
);
    assign s_out = a ^ b ^ cin;
    assign c_out = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_q;
    logic             fa_s, fa_c;
    logic             last_bit;

    fa u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .s_out (fa_s),
        .c_out (fa_c)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign s_next   = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_next;
                    carry <= fa_c;
                    if (last_bit) begin
                        sum_q <= s_next;
                        c_q   <= fa_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // On the last RUN cycle the carry flop holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state == RUN && last_bit)
            ovf_q <= carry ^ fa_c;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign sum_out = sum_q;
    assign c_out   = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl with an expected-result queue.
// Honours SERIAL_ADD_OVF_EN when computing the expected overflow flag.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum_out;
    logic         c_out;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   prev_accept = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] low;
        logic        c_into_msb;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
        c_into_msb = low[W-1];
        e.sum = full[W-1:0];
        e.c   = full[W];
`ifdef SERIAL_ADD_OVF_EN
        e.ovf = c_into_msb ^ full[W];
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    // Present operands for one cycle and record the expected result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) checkVal("wait_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        cin = ci;
        sb.push_back(model(a, b, ci));
        @(posedge clk); #1;
        prev_accept = accept_cyc;
        accept_cyc = cyc;
        in_valid = 1'b0;
        checkVal("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic waitResult();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkVal("latency", 32'(n), 32'(W));
    endtask

    // Compare against the oldest expected entry, then accept the result.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checkVal({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        checkVal({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkVal({tag, "_sum"}, 32'(sum_out), 32'(e.sum));
        checkVal({tag, "_c_out"}, 32'(c_out), 32'(e.c));
        checkVal({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        checkVal({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] held;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkVal("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("post_rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("post_rst_sum", 32'(sum_out), 32'h00);
        checkVal("post_rst_c_out", 32'(c_out), 32'd0);
        checkVal("post_rst_ovf", 32'(ovf), 32'd0);

        // out_ready in IDLE must not disturb anything
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkVal("idle_out_ready", 32'(in_ready), 32'd1);

        applyStimulus(8'h5A, 8'h33, 1'b0);
        waitResult();
        checkVal("5a33_sum_const", 32'(sum_out), 32'h8D);
        checkOutput("5a33");

        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitResult();
        checkVal("ff01_c_const", 32'(c_out), 32'd1);
        checkOutput("ff01");

        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitResult();
        checkVal("ffff_sum_const", 32'(sum_out), 32'hFF);
        checkOutput("ffff");

        // Back-to-back: each accept W+2 cycles after the previous one
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i * 37 + 5), 8'(i * 91 + 200), 1'(i));
            if (i > 0) checkVal("b2b_period", 32'(accept_cyc - prev_accept), 32'(W + 2));
            waitResult();
            checkOutput("b2b");
        end

        // Backpressure with a competing operand pulse
        applyStimulus(8'h12, 8'h34, 1'b1);
        waitResult();
        held = sum_out;
        checkVal("bp_sum_const", 32'(held), 32'h47);
        in_valid = 1'b1;
        a_in = 8'hAA;
        b_in = 8'hAA;
        cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkVal("bp_out_valid", 32'(out_valid), 32'd1);
            checkVal("bp_in_ready", 32'(in_ready), 32'd0);
            checkVal("bp_sum_stable", 32'(sum_out), 32'(held));
        end
        in_valid = 1'b0;
        checkOutput("bp");
        applyStimulus(8'h01, 8'h02, 1'b0);
        waitResult();
        checkOutput("bp_next");

        // Reset in the middle of RUN discards the operation
        applyStimulus(8'hC3, 8'h7E, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checkVal("midrst_out_valid", 32'(out_valid), 32'd0);
        checkVal("midrst_in_ready", 32'(in_ready), 32'd1);
        checkVal("midrst_sum", 32'(sum_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h10, 8'h20, 1'b0);
        waitResult();
        checkVal("1020_sum_const", 32'(sum_out), 32'h30);
        checkOutput("1020");

        // Signed overflow boundaries
        applyStimulus(8'h7F, 8'h01, 1'b0);
        waitResult();
        checkOutput("7f01");
        applyStimulus(8'h80, 8'h80, 1'b0);
        waitResult();
        checkOutput("8080");
        applyStimulus(8'h40, 8'h01, 1'b0);
        waitResult();
        checkVal("4001_ovf_const", 32'(ovf), 32'd0);
        checkOutput("4001");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
            waitResult();
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences one `fa` full-adder cell, LSB first, over WIDTH-bit operands.
- One addition per transaction, `in_valid`/`in_ready` handshake on operands, `out_valid`/`out_ready` handshake on the result.
- Trades WIDTH cycles of latency for a single adder cell.
- Used where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a_in, b_in, cin are valid.
- in_ready  output  1  block can accept operands.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum_out  output  WIDTH  registered sum.
- c_out  output  1  registered carry-out of the MSB.
- ovf  output  1  signed overflow flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; shift registers, counter and carry flop cleared.
  - sum_out=0, c_out=0, ovf=0, out_valid=0, in_ready=1 (in_ready follows IDLE).
  - Takes effect immediately, including mid-RUN or in DONE; the in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at an edge: latch a_in/b_in into shift registers A_sr/B_sr, carry flop <= cin, bit counter <= 0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and nothing is latched.
  - Each cycle, the `fa` cell is driven with a=A_sr[0], b=B_sr[0], cin=carry flop.
  - At each edge: s_out shifts into the MSB of S_sr; A_sr/B_sr shift right one bit; carry flop <= fa c_out; counter increments.
  - On the edge where counter==WIDTH-1, instead of incrementing:
    - sum_out <= final S_sr value, including the bit computed this cycle.
    - c_out <= fa c_out.
    - ovf updated (see Optional Feature).
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum_out/c_out/ovf held stable until the next DONE entry; out_valid stays high until out_ready=1.
  - out_ready=1 at an edge: go to IDLE.
  - A new operand is therefore accepted no earlier than the following edge. in_valid present during DONE is not consumed.
- Latency: operands accepted at edge E; out_valid goes high after edge E+WIDTH.
  - Minimum transaction period: WIDTH+2 cycles (accept, WIDTH RUN edges, one DONE handshake).
- Counter width: max(1, clog2(WIDTH)). For WIDTH=1, RUN lasts exactly one cycle.
- Arithmetic is unsigned modulo 2^WIDTH: {c_out, sum_out} == a_in + b_in + cin.
- sum_out/c_out never change while out_valid=1.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - An extra flop captures the carry into the MSB (the carry flop value during the last RUN cycle).
  - ovf <= (carry into MSB) XOR (carry out of MSB), registered at DONE entry, i.e. two's-complement signed overflow.
  - Held with sum_out; cleared by reset.
- Undefined: ovf is tied to 0, the extra flop is not built, and all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 then 1 with no stimulus -> in_ready=1, out_valid=0, sum_out=0x00, c_out=0, ovf=0.
- WIDTH=8, a_in=0x5A, b_in=0x33, cin=0, single-cycle in_valid -> in_ready low for 8 cycles; out_valid high after edge E+8 with sum_out=0x8D, c_out=0; out_ready=1 -> IDLE next edge.
- Carry chain:
  - 0xFF+0x01, cin=0 -> sum_out=0x00, c_out=1.
  - 0xFF+0xFF, cin=1 -> sum_out=0xFF, c_out=1.
  - Back-to-back transactions, each separated by exactly WIDTH+2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands -> out_valid stays 1, sum_out stable, in_ready=0, new operands not latched; accepted only after out_ready and the return to IDLE.
- Reset mid-RUN: assert rst_n=0 on cycle 3 of RUN -> immediately out_valid=0, in_ready=1, sum_out=0; then 0x10+0x20, cin=0 -> sum_out=0x30, c_out=0.
- With SERIAL_ADD_OVF_EN:
  - 0x7F+0x01 -> sum_out=0x80, c_out=0, ovf=1.
  - 0x80+0x80 -> sum_out=0x00, c_out=1, ovf=1.
  - 0x40+0x01 -> ovf=0.
  - Without the macro, the same three cases give ovf=0.
